// File: rtl/rom_weight_loader.sv
// Reads NUM_WORDS consecutive words of one ROM bank into a destination register file, then kicks the network controller.
// Optional running checksum of the written words: define ROM_LOAD_CHECKSUM_EN.
module rom_weight_loader #(
   parameter int unsigned DATA_W    = 32,
   parameter int unsigned ROM_AW    = 5,
   parameter int unsigned DST_AW    = 2,
   parameter int unsigned NUM_WORDS = 4,
   parameter int unsigned NUM_BANKS = 1,
   parameter int unsigned BASE_ADDR = 1,
   parameter int unsigned ROM_LAT   = 1,
   localparam int unsigned BANK_W   = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [BANK_W-1:0] bank,
   output logic [ROM_AW-1:0] rom_addr,
   input  logic [DATA_W-1:0] rom_data,
   output logic [DST_AW-1:0] dst_addr,
   output logic [DATA_W-1:0] dst_data,
   output logic              dst_we,
   output logic              busy,
   output logic              err,
   output logic              start_network_controller,
   output logic [DATA_W-1:0] checksum
);

   localparam int unsigned WAIT_W = $clog2(ROM_LAT + 1);
   localparam logic [DST_AW-1:0] LAST_IDX = DST_AW'(NUM_WORDS - 1);

   if (BASE_ADDR + NUM_BANKS * NUM_WORDS > 2 ** ROM_AW) begin : g_rom_range_err
      $error("rom_weight_loader: banks exceed ROM address space");
   end
   if (NUM_WORDS > 2 ** DST_AW || NUM_WORDS < 1) begin : g_words_err
      $error("rom_weight_loader: NUM_WORDS must be 1..2**DST_AW");
   end
   if (ROM_LAT < 1) begin : g_lat_err
      $error("rom_weight_loader: ROM_LAT must be >= 1");
   end

   typedef enum logic [1:0] {IDLE, FETCH, WRITE, DONE} state_t;

   state_t              state;
   logic                start_q;
   logic                start_edge;
   logic                bank_ok;
   logic                accept;
   logic [DST_AW-1:0]   idx;
   logic [WAIT_W-1:0]   wait_cnt;

   assign start_edge = start & ~start_q;
   assign bank_ok    = 32'(bank) < NUM_BANKS;
   assign accept     = (state == IDLE) && start_edge && bank_ok;

   always_ff @(posedge clk) begin
      if (!reset) begin
         state                    <= IDLE;
         start_q                  <= 1'b0;
         idx                      <= '0;
         wait_cnt                 <= '0;
         rom_addr                 <= '0;
         dst_addr                 <= '0;
         dst_data                 <= '0;
         dst_we                   <= 1'b0;
         busy                     <= 1'b0;
         err                      <= 1'b0;
         start_network_controller <= 1'b0;
      end else begin
         start_q                  <= start;
         dst_we                   <= 1'b0;
         err                      <= 1'b0;
         start_network_controller <= 1'b0;
         case (state)
            IDLE: begin
               if (start_edge) begin
                  if (bank_ok) begin
                     state    <= FETCH;
                     rom_addr <= ROM_AW'(BASE_ADDR + 32'(bank) * NUM_WORDS);
                     idx      <= '0;
                     wait_cnt <= '0;
                     busy     <= 1'b1;
                  end else begin
                     err <= 1'b1;
                  end
               end
            end
            // rom_addr was presented at entry; data is ready after ROM_LAT more edges
            FETCH: begin
               if (wait_cnt == WAIT_W'(ROM_LAT)) begin
                  dst_data <= rom_data;
                  dst_addr <= idx;
                  dst_we   <= 1'b1;
                  state    <= WRITE;
               end else begin
                  wait_cnt <= wait_cnt + 1'b1;
               end
            end
            WRITE: begin
               if (idx == LAST_IDX) begin
                  state                    <= DONE;
                  start_network_controller <= 1'b1;
               end else begin
                  idx      <= idx + 1'b1;
                  rom_addr <= rom_addr + 1'b1;
                  wait_cnt <= '0;
                  state    <= FETCH;
               end
            end
            DONE: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef ROM_LOAD_CHECKSUM_EN
   always_ff @(posedge clk) begin
      if (!reset)
         checksum <= '0;
      else if (accept)
         checksum <= '0;
      else if (state == WRITE)
         checksum <= checksum + dst_data;
   end
`else
   assign checksum = '0;
`endif

endmodule

// File: tb/tb_rom_weight_loader.sv
// Self-checking bench for rom_weight_loader: table vectors, hand sequences and randomized loads
// compared against a cycle-level reference model of the load schedule.
module tb_rom_weight_loader;

   localparam int DATA_W = 32, ROM_AW = 5, DST_AW = 2, NUM_WORDS = 4;
   localparam int NUM_BANKS = 3, BASE_ADDR = 1, ROM_LAT = 2;
   localparam int PER_WORD = ROM_LAT + 2;
`ifdef ROM_LOAD_CHECKSUM_EN
   localparam bit CK_EN = 1'b1;
`else
   localparam bit CK_EN = 1'b0;
`endif

   logic              clk = 1'b0;
   logic              reset;
   logic              start;
   logic [1:0]        bank;
   logic [ROM_AW-1:0] rom_addr;
   logic [DATA_W-1:0] rom_data;
   logic [DST_AW-1:0] dst_addr;
   logic [DATA_W-1:0] dst_data;
   logic              dst_we, busy, err, start_network_controller;
   logic [DATA_W-1:0] checksum;

   rom_weight_loader #(
      .DATA_W(DATA_W), .ROM_AW(ROM_AW), .DST_AW(DST_AW), .NUM_WORDS(NUM_WORDS),
      .NUM_BANKS(NUM_BANKS), .BASE_ADDR(BASE_ADDR), .ROM_LAT(ROM_LAT)
   ) dut (
      .clk(clk), .reset(reset), .start(start), .bank(bank),
      .rom_addr(rom_addr), .rom_data(rom_data),
      .dst_addr(dst_addr), .dst_data(dst_data), .dst_we(dst_we),
      .busy(busy), .err(err), .start_network_controller(start_network_controller),
      .checksum(checksum)
   );

   always #5 clk = ~clk;

   // ROM model: ROM_LAT-deep read pipeline starting at the edge that samples rom_addr
   logic [DATA_W-1:0] rom [32];
   logic [DATA_W-1:0] rom_p [ROM_LAT];
   always @(posedge clk) begin
      rom_p[0] <= rom[rom_addr];
      for (int i = 1; i < ROM_LAT; i++) rom_p[i] <= rom_p[i-1];
   end
   assign rom_data = rom_p[ROM_LAT-1];

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct { int c; logic [DST_AW-1:0] a; logic [DATA_W-1:0] d; } wr_t;
   wr_t wq[$];
   int  dq[$];
   int  eq[$];

   always @(negedge clk) begin
      if (dst_we) wq.push_back('{cyc, dst_addr, dst_data});
      if (start_network_controller) dq.push_back(cyc);
      if (err) eq.push_back(cyc);
   end

   int n_pass = 0, n_total = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   function automatic logic [63:0] all_outs();
      return {32'(rom_addr), 30'(dst_addr), 2'b0} ^ {dst_data, checksum} ^
             64'({dst_we, busy, err, start_network_controller}) |
             {dst_data, checksum} | 64'({dst_we, busy, err, start_network_controller}) |
             {32'(rom_addr), 32'(dst_addr)};
   endfunction

   task automatic wait_idle(input string tag);
      int n = 0;
      while (busy && n < 200) begin
         @(negedge clk);
         bank = 2'($urandom_range(0, 3));
         n++;
      end
      chk({tag, " idle"}, 32'(busy), 32'd0);
   endtask

   // Reference: word k of bank b lands at E0+(k+1)*PER_WORD-1, done at E0+NUM_WORDS*PER_WORD
   task automatic check_load(input int e0, input int b, input string tag);
      logic [DATA_W-1:0] sum = '0;
      chk({tag, " nwr"}, 32'(wq.size()), NUM_WORDS);
      for (int k = 0; k < NUM_WORDS; k++) begin
         logic [DATA_W-1:0] w = rom[BASE_ADDR + b * NUM_WORDS + k];
         sum += w;
         if (k < wq.size()) begin
            chk($sformatf("%s w%0d cyc", tag, k), 32'(wq[k].c), 32'(e0 + (k + 1) * PER_WORD - 1));
            chk($sformatf("%s w%0d addr", tag, k), 32'(wq[k].a), 32'(k));
            chk($sformatf("%s w%0d data", tag, k), wq[k].d, w);
         end
      end
      chk({tag, " ndone"}, 32'(dq.size()), 32'd1);
      if (dq.size() > 0) chk({tag, " done cyc"}, 32'(dq[0]), 32'(e0 + NUM_WORDS * PER_WORD));
      chk({tag, " nerr"}, 32'(eq.size()), 32'd0);
      chk({tag, " checksum"}, checksum, CK_EN ? sum : 32'd0);
   endtask

   task automatic run_load(input logic [1:0] b, input string tag);
      int e0;
      wq.delete(); dq.delete(); eq.delete();
      @(negedge clk);
      bank = b; start = 1'b1; e0 = cyc + 1;
      @(negedge clk);
      start = 1'b0;
      wait_idle(tag);
      repeat (2) @(negedge clk);
      check_load(e0, b, tag);
   endtask

   typedef struct { logic [1:0] bank; logic exp_err; logic exp_busy; logic [ROM_AW-1:0] exp_addr; } vec_t;
   vec_t tbl[4];

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int e0, late;
      for (int a = 0; a < 32; a++) rom[a] = $urandom();
      tbl[0] = '{2'd0, 1'b0, 1'b1, 5'd1};
      tbl[1] = '{2'd1, 1'b0, 1'b1, 5'd5};
      tbl[2] = '{2'd2, 1'b0, 1'b1, 5'd9};
      tbl[3] = '{2'd3, 1'b1, 1'b0, 5'd0};

      // reset held for 3 clocks, then 20 idle clocks
      reset = 1'b0; start = 1'b0; bank = '0;
      repeat (3) @(negedge clk);
      chk("reset outputs", all_outs() == 64'd0 ? 32'd1 : 32'd0, 32'd1);
      reset = 1'b1;
      wq.delete(); dq.delete(); eq.delete();
      repeat (20) @(negedge clk);
      chk("idle no we", 32'(wq.size()), 32'd0);
      chk("idle no done", 32'(dq.size()), 32'd0);
      chk("idle busy", 32'(busy), 32'd0);

      // table: one start per entry, check the accept cycle, then the full load
      for (int v = 0; v < 4; v++) begin
         string tag = $sformatf("tbl%0d", v);
         wq.delete(); dq.delete(); eq.delete();
         @(negedge clk);
         bank = tbl[v].bank; start = 1'b1; e0 = cyc + 1;
         @(negedge clk);
         start = 1'b0;
         chk({tag, " busy"}, 32'(busy), 32'(tbl[v].exp_busy));
         chk({tag, " err"}, 32'(err), 32'(tbl[v].exp_err));
         if (tbl[v].exp_err) begin
            @(negedge clk);
            chk({tag, " err pulse"}, 32'(err), 32'd0);
            chk({tag, " still idle"}, 32'(busy), 32'd0);
            repeat (3) @(negedge clk);
            chk({tag, " no we"}, 32'(wq.size()), 32'd0);
         end else begin
            chk({tag, " rom_addr"}, 32'(rom_addr), 32'(tbl[v].exp_addr));
            wait_idle(tag);
            repeat (2) @(negedge clk);
            check_load(e0, tbl[v].bank, tag);
         end
      end

      // retoggle while busy, then hold start high: exactly one load
      wq.delete(); dq.delete(); eq.delete();
      @(negedge clk);
      bank = 2'd2; start = 1'b1; e0 = cyc + 1;
      while (cyc < e0 + 3) @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      start = 1'b1;
      wait_idle("hold");
      repeat (10) @(negedge clk);
      check_load(e0, 2, "hold");
      chk("hold no reload", 32'(busy), 32'd0);
      start = 1'b0;
      @(negedge clk);
      run_load(2'd1, "after hold");

      // reset sampled at E0+6 abandons the load
      wq.delete(); dq.delete(); eq.delete();
      @(negedge clk);
      bank = 2'd0; start = 1'b1; e0 = cyc + 1;
      @(negedge clk);
      start = 1'b0;
      while (cyc < e0 + 5) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      chk("midreset outputs", all_outs() == 64'd0 ? 32'd1 : 32'd0, 32'd1);
      reset = 1'b1;
      repeat (40) @(negedge clk);
      late = 0;
      foreach (wq[i]) if (wq[i].c >= e0 + 6) late++;
      chk("midreset late we", 32'(late), 32'd0);
      chk("midreset pre we", 32'(wq.size()), 32'd1);
      chk("midreset no done", 32'(dq.size()), 32'd0);
      run_load(2'd0, "reload");

      // back-to-back loads: second bank all ones, checksum restarts
      run_load(2'd0, "ck1");
      for (int k = 0; k < NUM_WORDS; k++) rom[BASE_ADDR + NUM_WORDS + k] = 32'hFFFF_FFFF;
      run_load(2'd1, "ck2");
      chk("ck2 value", checksum, CK_EN ? 32'hFFFF_FFFC : 32'd0);

      // randomized loads with fresh ROM contents and random gaps
      for (int r = 0; r < 8; r++) begin
         for (int a = 0; a < 32; a++) rom[a] = $urandom();
         repeat ($urandom_range(0, 5)) @(negedge clk);
         run_load(2'($urandom_range(0, NUM_BANKS - 1)), $sformatf("rnd%0d", r));
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
